uart_mem_byte_writer: RTL

Avalon-MM initiator that packs a byte stream (received UART characters) into 32-bit little-endian words and writes them into the 2048 x 32 single-port on-chip memory. It is the writing end of that memory's slave port, keeps a circular word pointer inside a configurable window, and supports partial-word flush with byte enables. It sits between the UART receive path and the on-chip memory in the UART subsystem.

---
 rtl/uart_mem_byte_writer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_mem_byte_writer.sv
// Packs a received byte stream into little-endian 32-bit words and writes them
// over Avalon-MM into a circular window of the on-chip memory.
module uart_mem_byte_writer #(
    parameter int unsigned BASE_WORD   = 0,
    parameter int unsigned DEPTH_WORDS = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    input  logic        clear,
    output logic [10:0] address,
    output logic [3:0]  byteenable,
    output logic        chipselect,
    output logic        write,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    output logic        clken,
    output logic [10:0] wr_ptr,
    output logic        wrapped
);
    localparam int unsigned AW  = 11;
    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = DW / 8;
    localparam int unsigned LW  = 2;

    localparam logic [AW-1:0] PTR_FIRST = AW'(BASE_WORD);
    localparam logic [AW-1:0] PTR_LAST  = AW'(BASE_WORD + DEPTH_WORDS - 1);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_WRITE = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [BEW-1:0]  mask_q, mask_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [BEW-1:0]  be_q, be_d;
    logic            write_q, write_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            wrapped_q, wrapped_d;
    logic            clken_q;

    // State register; clken simply follows reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FILL;
            lane_q    <= '0;
            mask_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            write_q   <= 1'b0;
            ptr_q     <= PTR_FIRST;
            wrapped_q <= 1'b0;
            clken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            mask_q    <= mask_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            write_q   <= write_d;
            ptr_q     <= ptr_d;
            wrapped_q <= wrapped_d;
            clken_q   <= 1'b1;
        end
    end

    assign in_ready = (state_q == S_FILL) && !clear;

    // Next state: a same-cycle byte is packed before flush looks at the mask.
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        mask_d    = mask_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        write_d   = write_q;
        ptr_d     = ptr_q;
        wrapped_d = wrapped_q;

        if (clear) begin
            state_d   = S_FILL;
            lane_d    = '0;
            mask_d    = '0;
            wdata_d   = '0;
            be_d      = '0;
            write_d   = 1'b0;
            ptr_d     = PTR_FIRST;
            wrapped_d = 1'b0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (in_valid) begin
                        wdata_d[8*lane_q +: 8] = in_data;
                        mask_d = mask_q | (BEW'(1) << lane_q);
                        lane_d = lane_q + LW'(1);
                    end
                    if ((in_valid && lane_q == LW'(3)) || (flush && mask_d != '0)) begin
                        state_d = S_WRITE;
                        be_d    = mask_d;
                        write_d = 1'b1;
                    end
                end
                S_WRITE: begin
                    if (!waitrequest) begin
                        state_d = S_FILL;
                        lane_d  = '0;
                        mask_d  = '0;
                        wdata_d = '0;
                        be_d    = '0;
                        write_d = 1'b0;
                        if (ptr_q == PTR_LAST) begin
                            ptr_d     = PTR_FIRST;
                            wrapped_d = 1'b1;
                        end else begin
                            ptr_d = ptr_q + AW'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_FILL;
                end
            endcase
        end
    end

    assign address    = ptr_q;
    assign wr_ptr     = ptr_q;
    assign byteenable = be_q;
    assign chipselect = write_q;
    assign write      = write_q;
    assign writedata  = wdata_q;
    assign wrapped    = wrapped_q;
    assign clken      = clken_q;

endmodule
